mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares one single-port, synchronous-read unified RAM between the CPU instruction-fetch port and its load/store data port.
- Arbitrates per cycle. Data accesses have priority, and a bounded-starvation counter guarantees fetch progress.
- Tags the one outstanding access so each read response returns to the correct requester.
- Sits between the pipelined core (fetch stage and execute-stage memory signals) and the RAM macro; grant outputs drive core stalls.

Parameters:
- ADDR_W, 12, RAM word-address width; depth is 2**ADDR_W 32-bit words.
- STARVE_MAX, 4, consecutive fetch losses (>=1) after which fetch wins the next conflict.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- i_req  input  1  fetch request
- i_addr  input  32  fetch byte address
- i_gnt  output  1  fetch accepted this cycle (combinational)
- i_valid  output  1  fetch data valid (one cycle after i_gnt)
- i_rdata  output  32  fetch data
- d_req  input  1  data request
- d_addr  input  32  data byte address
- d_wdata  input  32  store data, pre-replicated by the core
- d_wstrb  input  4  byte write enables; 0 = load, nonzero = store
- d_gnt  output  1  data accepted this cycle (combinational)
- d_valid  output  1  data response, one cycle after d_gnt (load data or store ack)
- d_rdata  output  32  load data
- ram_en  output  1  RAM access enable
- ram_addr  output  ADDR_W  RAM word address
- ram_we  output  4  RAM byte write enables
- ram_wdata  output  32  RAM write data
- ram_rdata  input  32  RAM read data, valid one cycle after ram_en with ram_we==0

Behaviour:
- Reset state: starve_cnt=0, pend_i=0, pend_d=0. Outputs i_valid=0, d_valid=0, i_gnt=0, d_gnt=0, ram_en=0, ram_we=0 while reset is high.
- Arbitration (combinational, all gated by !reset):
  - d_req only: d_gnt=1.
  - i_req only: i_gnt=1.
  - Both requesting: d_gnt=1, unless starve_cnt==STARVE_MAX, in which case i_gnt=1.
  - Never both grants in one cycle.
- RAM drive:
  - ram_en = i_gnt|d_gnt.
  - ram_addr = winner address bits [ADDR_W+1:2]. Low two bits and bits above ADDR_W+1 are ignored; out-of-range addresses alias, with no error.
  - ram_we = d_gnt ? d_wstrb : 0.
  - ram_wdata = d_wdata.
  - When idle: ram_addr and ram_wdata are don't-care, ram_we=0.
- Response tagging:
  - pend_i <= i_gnt and pend_d <= d_gnt, every cycle.
  - i_valid = pend_i; d_valid = pend_d.
  - i_rdata = d_rdata = ram_rdata, combinational passthrough; meaningful only when the matching valid is high.
  - A store produces d_valid one cycle later as an ack; d_rdata is then don't-care.
- Latency and throughput:
  - Exactly one cycle from grant to valid.
  - Back-to-back grants allowed every cycle, so full throughput with a single requester.
  - No request buffering: an ungranted requester holds req/addr/wdata/wstrb stable and retries; the arbiter keeps no state for it.
- Starvation counter (width clog2(STARVE_MAX+1)):
  - Increments when i_req && d_gnt (fetch lost).
  - Clears to 0 when i_gnt.
  - Holds otherwise, including when i_req is low.
  - Saturates at STARVE_MAX; when saturated, fetch wins the next conflict, then the counter clears.
- Reset mid-operation:
  - Reset asserted in the cycle after a grant forces i_valid/d_valid low.
  - pend_i and pend_d clear, so no response leaks out after reset.
- The RAM read-during-write result is irrelevant: the arbiter never reads and writes in the same cycle.

Test Plan:
- Fetch only: i_req=1 with i_addr=0,4,8 over consecutive cycles, RAM preloaded word[n]=n+0x100 -> i_gnt=1 each cycle; i_valid on cycles 1..3 with i_rdata=0x100,0x101,0x102; d_valid stays 0.
- Store then load: d_wstrb=4'b0100, d_wdata=32'hAAAAAAAA, d_addr=0x10 on a word holding 0x11223344; next cycle load 0x10 -> ram_we=4'b0100; load response d_rdata=0x11AA3344; d_valid high in both response cycles.
- Conflict: i_req=d_req=1 for one cycle, starve_cnt=0 -> d_gnt=1, i_gnt=0, starve_cnt=1; next cycle d_req=0 -> i_gnt=1, starve_cnt=0.
- Starvation, STARVE_MAX=4: i_req=d_req=1 held 10 cycles -> grant sequence D,D,D,D,I,D,D,D,D,I.
- Reset mid-read: d_gnt for a load in cycle t, reset=1 in cycle t+1 -> d_valid=0 in t+1, ram_en=0 during reset, starve_cnt=0 after release.
- Misaligned/aliased address: d_addr=0x0000_4013 with ADDR_W=12 -> ram_addr=12'h004, same data as d_addr=0x10.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one synchronous-read RAM between CPU fetch and load/store ports
// Ports: clk/reset (sync, active-high); i_req/i_addr -> i_gnt/i_valid/i_rdata (fetch);
// d_req/d_addr/d_wdata/d_wstrb -> d_gnt/d_valid/d_rdata (data, wstrb==0 is a load);
// ram_en/ram_addr/ram_we/ram_wdata/ram_rdata drive the single-port RAM macro.
module mem_port_arbiter #(
  parameter int ADDR_W     = 12,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [31:0]       i_addr,
  output logic              i_gnt,
  output logic              i_valid,
  output logic [31:0]       i_rdata,
  input  logic              d_req,
  input  logic [31:0]       d_addr,
  input  logic [31:0]       d_wdata,
  input  logic [3:0]        d_wstrb,
  output logic              d_gnt,
  output logic              d_valid,
  output logic [31:0]       d_rdata,
  output logic              ram_en,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [3:0]        ram_we,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);
  localparam int CW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] SAT = CW'(STARVE_MAX);
  logic [CW-1:0] starve_cnt;
  logic pend_i, pend_d, starved, unused_addr;
  assign starved = starve_cnt == SAT;
  // data wins conflicts unless fetch has lost STARVE_MAX times in a row
  assign i_gnt = !reset & i_req & (!d_req | starved);
  assign d_gnt = !reset & d_req & !(i_req & starved);
  assign ram_en = i_gnt | d_gnt;
  // byte offset and bits above the RAM depth are dropped, so addresses alias
  assign ram_addr = i_gnt ? i_addr[ADDR_W+1:2] : d_addr[ADDR_W+1:2];
  assign ram_we = d_gnt ? d_wstrb : 4'b0;
  assign ram_wdata = d_wdata;
  assign unused_addr = ^{i_addr[31:ADDR_W+2], i_addr[1:0], d_addr[31:ADDR_W+2], d_addr[1:0]};
  // gating by reset kills a response whose grant preceded the reset cycle
  assign i_valid = pend_i & !reset;
  assign d_valid = pend_d & !reset;
  assign i_rdata = ram_rdata;
  assign d_rdata = ram_rdata;
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_i <= 1'b0;
      pend_d <= 1'b0;
      starve_cnt <= '0;
    end else begin
      pend_i <= i_gnt;
      pend_d <= d_gnt;
      starve_cnt <= i_gnt ? '0 : (i_req & d_gnt & !starved) ? starve_cnt + 1'b1 : starve_cnt;
    end
  end
endmodule
